// File: rtl/bram_ctrl_pkg.sv
// Shared definitions for the BRAM request controller: FSM encodings and counter width.
package bram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CAPT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int CNT_W = 16;

endpackage

// File: rtl/bram_single_port_ram.sv
// Single-port block RAM with registered read; the output holds while a write is in progress.
module bram_single_port_ram #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= din;
      end else begin
         dout <= mem[addr];
      end
   end

endmodule

// File: rtl/bram_req_ctrl.sv
// Command/response front end for a registered-read single-port BRAM.
//
// state | meaning
// IDLE  | ready for a command; writes complete here at one per cycle
// ISSUE | read address presented, RAM samples it on the next edge
// CAPT  | RAM output valid, captured into rsp_rdata on the next edge
// RESP  | response held until the consumer accepts it
module bram_req_ctrl
   import bram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_we,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic                  busy,
   output logic [CNT_W-1:0]      wr_count,
   output logic [CNT_W-1:0]      rd_count
);

   state_t state_q;
   state_t state_d;
   logic   ready_en_q;
   logic   cmd_accept;
   logic   capture;
   logic   rsp_done;

   // ready_en_q keeps cmd_ready low until the first edge after reset release
   assign cmd_ready  = (state_q == IDLE) && ready_en_q;
   assign busy       = (state_q != IDLE);
   assign cmd_accept = cmd_valid && cmd_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_en_q <= 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      capture  = 1'b0;
      rsp_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_accept && !cmd_we) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = CAPT;
         end
         CAPT: begin
            capture = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_done = 1'b1;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_din   <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         wr_count  <= '0;
         rd_count  <= '0;
      end else begin
         ram_we <= cmd_accept && cmd_we;
         if (cmd_accept) begin
            ram_addr <= cmd_addr;
            if (cmd_we) begin
               ram_din  <= cmd_wdata;
               wr_count <= wr_count + 1'b1;
            end else begin
               rd_count <= rd_count + 1'b1;
            end
         end
         if (capture) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= ram_dout;
         end else if (rsp_done) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bram_req_ctrl.sv
// Directed self-checking bench: controller attached to a 1K x 8 registered-read RAM.
module tb_bram_req_ctrl;

   localparam int AW = 10;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_we;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;
   logic          busy;
   logic [15:0]   wr_count;
   logic [15:0]   rd_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   bram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
      .busy(busy), .wr_count(wr_count), .rd_count(rd_count)
   );

   bram_single_port_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_ram (
      .clk(clk), .we(ram_we), .addr(ram_addr), .din(ram_din), .dout(ram_dout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Read with rsp_ready=1: rsp_valid rises exactly two edges after acceptance
   task automatic read_check(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
      rsp_ready = 1'b1;
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      cmd_addr  = a;
      tick();
      cmd_valid = 1'b0;
      chk({tag, "_acc_busy"}, 32'(busy), 32'd1);
      chk({tag, "_acc_we"}, 32'(ram_we), 32'd0);
      tick();
      chk({tag, "_n1_valid"}, 32'(rsp_valid), 32'd0);
      tick();
      chk({tag, "_n2_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_n2_rdata"}, 32'(rsp_rdata), 32'(exp));
      tick();
      chk({tag, "_n3_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_n3_ready"}, 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_we    = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      rsp_ready = 1'b1;

      // reset
      #2;
      chk("rst_async_busy", 32'(busy), 32'd0);
      chk("rst_async_ready", 32'(cmd_ready), 32'd0);
      repeat (3) tick();
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_ram_din", 32'(ram_din), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      chk("rst_counts", {wr_count, rd_count}, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_ready_before_edge", 32'(cmd_ready), 32'd0);
      tick();
      chk("rel_ready_after_edge", 32'(cmd_ready), 32'd1);

      // write 0x005 <- 0xA5, then read it back
      cmd_valid = 1'b1;
      cmd_we    = 1'b1;
      cmd_addr  = 10'h005;
      cmd_wdata = 8'hA5;
      tick();
      cmd_valid = 1'b0;
      chk("wr_ram_we", 32'(ram_we), 32'd1);
      chk("wr_ram_addr", 32'(ram_addr), 32'h005);
      chk("wr_ram_din", 32'(ram_din), 32'hA5);
      chk("wr_busy", 32'(busy), 32'd0);
      chk("wr_count1", 32'(wr_count), 32'd1);
      read_check(10'h005, 8'hA5, "rd005");
      chk("rd_counts", {wr_count, rd_count}, {16'd1, 16'd1});

      // back-to-back writes 0x3FF..0x3FC
      for (int i = 0; i < 4; i++) begin
         cmd_valid = 1'b1;
         cmd_we    = 1'b1;
         cmd_addr  = 10'(10'h3FF - i);
         cmd_wdata = 8'(8'h11 + i);
         tick();
         chk($sformatf("b2b_we%0d", i), 32'(ram_we), 32'd1);
         chk($sformatf("b2b_addr%0d", i), 32'(ram_addr), 32'(10'h3FF - i));
      end
      cmd_valid = 1'b0;
      tick();
      chk("b2b_we_fall", 32'(ram_we), 32'd0);
      chk("b2b_addr_hold", 32'(ram_addr), 32'h3FC);
      chk("b2b_din_hold", 32'(ram_din), 32'h14);
      chk("b2b_wr_count", 32'(wr_count), 32'd5);
      read_check(10'h3FC, 8'h14, "rd3fc");

      // response backpressure with a competing write offered
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      cmd_addr  = 10'h005;
      tick();
      cmd_we    = 1'b1;
      cmd_wdata = 8'h5A;
      tick();
      tick();
      chk("bp_valid_rise", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", 32'(rsp_rdata), 32'hA5);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("bp_hold_valid%0d", i), 32'(rsp_valid), 32'd1);
         chk($sformatf("bp_hold_rdata%0d", i), 32'(rsp_rdata), 32'hA5);
         chk($sformatf("bp_hold_ready%0d", i), 32'(cmd_ready), 32'd0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      chk("bp_release_valid", 32'(rsp_valid), 32'd0);
      chk("bp_release_busy", 32'(busy), 32'd0);
      chk("bp_counts", {wr_count, rd_count}, {16'd5, 16'd3});

      // reset while a write strobe is high
      cmd_valid = 1'b1;
      cmd_we    = 1'b1;
      cmd_addr  = 10'h200;
      cmd_wdata = 8'h77;
      tick();
      cmd_valid = 1'b0;
      chk("rstwr_we_before", 32'(ram_we), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rstwr_we_forced", 32'(ram_we), 32'd0);
      rst_n = 1'b1;
      tick();

      // reset in CAPT drops the response
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      cmd_addr  = 10'h005;
      tick();
      cmd_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("rstrd_valid", 32'(rsp_valid), 32'd0);
      chk("rstrd_busy", 32'(busy), 32'd0);
      chk("rstrd_counts", {wr_count, rd_count}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("rstrd_no_pulse%0d", i), 32'(rsp_valid), 32'd0);
      end
      rst_n = 1'b1;
      tick();
      chk("rstrd_post_valid", 32'(rsp_valid), 32'd0);
      read_check(10'h005, 8'hA5, "rd005_post");

      // write counter wrap
      cmd_valid = 1'b1;
      cmd_we    = 1'b1;
      cmd_addr  = 10'h100;
      for (int i = 0; i < 65535; i++) begin
         cmd_wdata = 8'(i);
         tick();
      end
      chk("wrap_ffff", 32'(wr_count), 32'hFFFF);
      tick();
      cmd_valid = 1'b0;
      chk("wrap_zero", 32'(wr_count), 32'h0000);
      chk("wrap_rd_unchanged", 32'(rd_count), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
